// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_B     = 2'd0;
  localparam logic [1:0] SIZE_H     = 2'd1;
  localparam logic [1:0] SIZE_W     = 2'd2;
  localparam logic [1:0] IO_HI_BITS = 2'b11;

  // Index of the last byte of an access; the unused size code behaves as a word.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_lane_asm.sv
// Byte lane index plus four capture lanes: assembles read bytes into a word and
// selects the outgoing store byte.
module byte_lane_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        cap_en,
  input  logic        step,
  input  logic [7:0]  din,
  input  logic [31:0] wdata,
  output logic [31:0] word_cap,
  output logic [7:0]  wr_byte
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] lanes_q, lanes_d;

  // Next lane contents: clear on a new access, otherwise capture or advance.
  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    if (clr) begin
      idx_d   = '0;
      lanes_d = '0;
    end else if (cap_en) begin
      lanes_d[{idx_q, 3'b000} +: 8] = din;
      idx_d                         = idx_q + 2'd1;
    end else if (step) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // The word including the byte being captured this cycle, so completion can register it directly.
  assign word_cap = lanes_d;
  assign wr_byte  = wdata[{idx_q, 3'b000} +: 8];

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one byte-wide RAM/IO port between instruction fetch
// and the MEM stage.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ARB_IDLE | no transfer; arbitrate (MEM first) unless a done is high
//  ARB_RD   | issuing read addresses and capturing ram_din one cycle later
//  ARB_WR   | writing one byte per cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  arb_state_e        state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              cap_q, cap_d;
  logic [1:0]        left_q, left_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              lane_clr, cap_en, wr_step;
  logic [31:0]       word_cap;
  logic [7:0]        wr_byte;

  byte_lane_asm u_lanes (
    .clk      (clk),
    .rst      (rst),
    .clr      (lane_clr),
    .cap_en   (cap_en),
    .step     (wr_step),
    .din      (ram_din),
    .wdata    (mem_wdata),
    .word_cap (word_cap),
    .wr_byte  (wr_byte)
  );

  // Next state, address sequencing and completion; everything holds while rdy is low.
  always_comb begin
    state_d      = state_q;
    owner_mem_d  = owner_mem_q;
    ram_a_d      = ram_a_q;
    cap_addr_d   = cap_addr_q;
    addr_valid_d = addr_valid_q;
    cap_d        = cap_q;
    left_d       = left_q;
    if_done_d    = if_done_q;
    mem_done_d   = mem_done_q;
    if_inst_d    = if_inst_q;
    mem_rdata_d  = mem_rdata_q;
    lane_clr     = 1'b0;
    cap_en       = 1'b0;
    wr_step      = 1'b0;

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        ARB_IDLE: begin
          // A done pulse masks requests so the finished requester can drop its level.
          if (!(if_done_q || mem_done_q)) begin
            if (mem_req) begin
              owner_mem_d  = 1'b1;
              state_d      = mem_we ? ARB_WR : ARB_RD;
              ram_a_d      = mem_addr;
              left_d       = last_index(mem_size);
              addr_valid_d = 1'b1;
              cap_d        = 1'b0;
              lane_clr     = 1'b1;
            end else if (if_req) begin
              owner_mem_d  = 1'b0;
              state_d      = ARB_RD;
              ram_a_d      = if_addr;
              left_d       = 2'(FETCH_BYTES - 1);
              addr_valid_d = 1'b1;
              cap_d        = 1'b0;
              lane_clr     = 1'b1;
            end
          end
        end
        ARB_RD: begin
          if (!owner_mem_q && !if_req) begin
            state_d      = ARB_IDLE;
            ram_a_d      = '0;
            addr_valid_d = 1'b0;
            cap_d        = 1'b0;
          end else begin
            cap_en = cap_q;
            if (addr_valid_q) begin
              cap_d      = 1'b1;
              cap_addr_d = ram_a_q;
              if (left_q != 2'd0) begin
                ram_a_d = ram_a_q + ADDR_W'(1);
                left_d  = left_q - 2'd1;
              end else begin
                ram_a_d      = '0;
                addr_valid_d = 1'b0;
              end
            end else begin
              cap_d = 1'b0;
            end
            if (cap_q && !addr_valid_q) begin
              state_d = ARB_IDLE;
              if (owner_mem_q) begin
                mem_done_d  = 1'b1;
                mem_rdata_d = word_cap;
              end else begin
                if_done_d = 1'b1;
                if_inst_d = word_cap;
              end
            end
          end
        end
        ARB_WR: begin
          wr_step = 1'b1;
          if (left_q != 2'd0) begin
            ram_a_d = ram_a_q + ADDR_W'(1);
            left_d  = left_q - 2'd1;
          end else begin
            state_d    = ARB_IDLE;
            ram_a_d    = '0;
            mem_done_d = 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_mem_q  <= 1'b0;
      ram_a_q      <= '0;
      cap_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      cap_q        <= 1'b0;
      left_q       <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      if_inst_q    <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_mem_q  <= owner_mem_d;
      ram_a_q      <= ram_a_d;
      cap_addr_q   <= cap_addr_d;
      addr_valid_q <= addr_valid_d;
      cap_q        <= cap_d;
      left_q       <= left_d;
      if_done_q    <= if_done_d;
      mem_done_q   <= mem_done_d;
      if_inst_q    <= if_inst_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // While stalled with a byte in flight, re-drive that byte's address so ram_din
  // holds it again in the first cycle after rdy returns.
  assign ram_a     = (!rdy && state_q == ARB_RD && cap_q) ? cap_addr_q : ram_a_q;
  assign ram_wr    = (state_q == ARB_WR) && rdy;
  assign ram_dout  = ram_wr ? wr_byte : 8'h00;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected done results
// and bus cycles; monitors pop and compare as the DUT presents them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  done_t exp_if[$];
  done_t exp_mem[$];
  bus_t  exp_bus[$];
  logic [7:0] ram_m [logic [31:0]];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_m.exists(a)) return ram_m[a];
    return 8'hFF;
  endfunction

  // Synchronous RAM model: read data reflects the address of the previous cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_din <= ram_rd(ram_a);
    if (ram_wr) ram_m[ram_a] = ram_dout;
  end

  // Done monitor.
  always @(negedge clk) begin
    done_t e;
    if (!rst && rdy && if_done) begin
      total++;
      if (exp_if.size() == 0) begin
        bad++;
        $display("FAIL if_done_unexpected: got pulse inst=%h at cycle %0d, required none", if_inst, cyc);
      end else begin
        e = exp_if.pop_front();
        if (if_inst !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL if_inst: got %h at cycle %0d, required %h at cycle %0d", if_inst, cyc, e.data, e.cyc);
        end
      end
    end
    if (!rst && rdy && mem_done) begin
      total++;
      if (exp_mem.size() == 0) begin
        bad++;
        $display("FAIL mem_done_unexpected: got pulse rdata=%h at cycle %0d, required none", mem_rdata, cyc);
      end else begin
        e = exp_mem.pop_front();
        if ((e.chk_data && mem_rdata !== e.data) || cyc != e.cyc) begin
          bad++;
          $display("FAIL mem_rdata: got %h at cycle %0d, required %h at cycle %0d", mem_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  // Bus monitor: every active (non-zero address or write) rdy-high cycle must match the next expected cycle.
  always @(negedge clk) begin
    bus_t b;
    if (!rst && rdy && (ram_wr || ram_a != 32'h0)) begin
      total++;
      if (exp_bus.size() == 0) begin
        bad++;
        $display("FAIL bus_unexpected: got a=%h wr=%b dout=%h, required idle bus", ram_a, ram_wr, ram_dout);
      end else begin
        b = exp_bus.pop_front();
        if (ram_a !== b.addr || ram_wr !== b.wr || ram_dout !== b.dout) begin
          bad++;
          $display("FAIL bus: got a=%h wr=%b dout=%h, required a=%h wr=%b dout=%h",
                   ram_a, ram_wr, ram_dout, b.addr, b.wr, b.dout);
        end
      end
    end
    if (!rst && rdy && ram_a[17:16] == IO_HI_BITS) begin
      total++;
      if (!ram_wr) begin
        bad++;
        $display("FAIL io_read: got read of IO address %h, required no IO read", ram_a);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic push_reads(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_bus.push_back('{a + 32'(i), 1'b0, 8'h00});
  endtask

  task automatic wait_done(input bit is_mem);
    int n = 0;
    while (((is_mem ? mem_done : if_done) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL %s_done_timeout: got no pulse in 40 cycles, required one", is_mem ? "mem" : "if");
    end
  endtask

  initial begin
    int c;
    ram_m[32'h100] = 8'h13; ram_m[32'h101] = 8'h05; ram_m[32'h102] = 8'h00; ram_m[32'h103] = 8'h00;
    ram_m[32'h200] = 8'h11; ram_m[32'h201] = 8'h22; ram_m[32'h202] = 8'h33; ram_m[32'h203] = 8'h44;
    ram_m[32'h300] = 8'h93; ram_m[32'h301] = 8'h00; ram_m[32'h302] = 8'h10; ram_m[32'h303] = 8'h00;
    ram_m[32'h1FFFF] = 8'h80;
    ram_m[32'h210] = 8'hAA; ram_m[32'h211] = 8'hBB;

    tick(); tick();
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_mem_done", 32'(mem_done), 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // 1: word fetch
    c = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    exp_if.push_back('{32'h00000513, c + 6, 1'b1});
    push_reads(32'h100, 4);
    wait_done(1'b0);
    if_req = 1'b0;
    tick();

    // 2: simultaneous requests, MEM first
    c = cyc;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_W; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    exp_mem.push_back('{32'h44332211, c + 6, 1'b1});
    exp_if.push_back('{32'h00100093, c + 13, 1'b1});
    push_reads(32'h200, 4);
    push_reads(32'h300, 4);
    wait_done(1'b1);
    mem_req = 1'b0;
    wait_done(1'b0);
    if_req = 1'b0;
    tick();

    // 3: IO half store
    c = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = SIZE_H; mem_addr = 32'h30000; mem_wdata = 32'h0000BEEF;
    exp_mem.push_back('{32'h0, c + 3, 1'b0});
    exp_bus.push_back('{32'h30000, 1'b1, 8'hEF});
    exp_bus.push_back('{32'h30001, 1'b1, 8'hBE});
    wait_done(1'b1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();

    // 4: byte load, zero-extended
    c = cyc;
    mem_req = 1'b1; mem_size = SIZE_B; mem_addr = 32'h1FFFF;
    exp_mem.push_back('{32'h00000080, c + 3, 1'b1});
    push_reads(32'h1FFFF, 1);
    wait_done(1'b1);
    mem_req = 1'b0;
    tick();

    // 5: rdy low for three cycles after byte 1 issued
    c = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    exp_if.push_back('{32'h00000513, c + 9, 1'b1});
    push_reads(32'h100, 4);
    tick(); tick(); tick();
    rdy = 1'b0;
    tick();
    chk("stall_replay_a1", ram_a, 32'h101);
    chk("stall_wr1", 32'(ram_wr), 32'h0);
    tick();
    chk("stall_replay_a2", ram_a, 32'h101);
    tick();
    rdy = 1'b1;
    wait_done(1'b0);
    if_req = 1'b0;
    tick();

    // 6: fetch abort after two bytes, then a half load
    c = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    push_reads(32'h100, 2);
    tick(); tick();
    if_req = 1'b0;
    tick();
    chk("abort_idle_a", ram_a, 32'h0);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_H; mem_addr = 32'h210;
    exp_mem.push_back('{32'h0000BBAA, c + 7, 1'b1});
    push_reads(32'h210, 2);
    wait_done(1'b1);
    mem_req = 1'b0;
    tick();

    // reset in the middle of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_size = SIZE_W; mem_addr = 32'h400; mem_wdata = 32'h11223344;
    exp_bus.push_back('{32'h400, 1'b1, 8'h44});
    exp_bus.push_back('{32'h401, 1'b1, 8'h33});
    tick(); tick();
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(ram_wr), 32'h0);
    chk("rst_mid_a", ram_a, 32'h0);
    chk("rst_mid_dout", 32'(ram_dout), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // size code 3 behaves as a word load
    c = cyc;
    mem_req = 1'b1; mem_size = 2'd3; mem_addr = 32'h200;
    exp_mem.push_back('{32'h44332211, c + 6, 1'b1});
    push_reads(32'h200, 4);
    wait_done(1'b1);
    mem_req = 1'b0;

    repeat (10) tick();
    chk("left_if", 32'(exp_if.size()), 32'h0);
    chk("left_mem", 32'(exp_mem.size()), 32'h0);
    chk("left_bus", 32'(exp_bus.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, required finish");
    $fatal(1);
  end

endmodule
